board_state: RTL and testbench
==============================

# board_state

Board-state stage sitting directly downstream of the move-input stage: consumes the registered `location`/`mark` pair, maintains the nine cell registers `a0`..`a8` with per-player three-mark elimination (placing a 4th mark removes that player's oldest), and detects a three-in-a-row win. Its `a0`..`a8` and `gameend` outputs feed back into the move-input stage and onward to the display logic.

## Interface
- No parameters. Queue depth fixed at 3 per player; cell count fixed at 9.
- `clk`  input  1  100 Hz system clock
- `rst`  input  1  asynchronous, active-low reset
- `location`  input  4  cell of the latest move, 0..8; 9 = none
- `mark`  input  2  latest move: 2'b10 X, 2'b01 O, 2'b00 no move
- `a0`..`a8`  output  2 each  cell contents: 2'b10 X, 2'b01 O, 2'b00 empty
- `gameend`  output  2  2'b10 X won, 2'b01 O won, 2'b00 in play
- `fadeX`, `fadeO`  output  4 each  cell that player's next placement will clear; 9 when the player holds fewer than 3 marks
- `countX`, `countO`  output  2 each  marks currently on board per player, 0..3

## Operation
- Move detection: registers `prevLoc` (reset 9) and `prevMark` (reset 2'b00) sample `location`/`mark` every cycle. Move event = `mark` is 2'b10 or 2'b01, `location` ≤ 8, and {`location`,`mark`} ≠ {`prevLoc`,`prevMark`}.
- Move accepted only if the event is present, `gameend` == 2'b00 and the target cell is 2'b00. Otherwise nothing changes (prev registers still update).
- Per-player age queue: 3 entries of 4 bits plus a 2-bit count; entry 0 = oldest.
  - count < 3: append location, count+1.
  - count == 3: clear cell at entry 0 to 2'b00, shift entries down, append location at entry 2; count stays 3.
  - The write of the new cell and the clear of the oldest cell occur in the same cycle; they are always distinct cells.
- The opponent's queue and cells are never touched by a move.
- `fadeX`/`fadeO` = entry 0 of the respective queue when count == 3, else 9.
- Win check over the 8 lines (rows 0-1-2, 3-4-5, 6-7-8; columns 0-3-6, 1-4-7, 2-5-8; diagonals 0-4-8, 2-4-6) on the registered board after elimination. All three cells 2'b10 → X wins; all 2'b01 → O wins; if both (unreachable) X takes priority.
- `gameend` is sticky: once non-zero it holds until reset. Moves are then ignored and the board is frozen.

## Timing
- Reset (async, `rst` low): all `a*` = 2'b00, `gameend` = 2'b00, counts 0, queue entries 9, `fadeX`/`fadeO` = 9, `prevLoc` = 9, `prevMark` = 2'b00.
- Cycle t: `location`/`mark` change. End of cycle t: cell, queue, count and fade outputs are updated (1-cycle latency).
- End of cycle t+1: `gameend` updated from the board registered at t. Moves arriving at t+1 are still evaluated against the old `gameend`. Up to one extra move may land in that window; its effect is kept and the win check at t+2 uses the updated board.
- Held inputs: a pair held for many cycles produces exactly one event.
- A pair that drops to `mark` 2'b00 and returns to the same pair produces a new event; it is rejected because the cell is occupied.
- Reset asserted mid-game clears everything immediately. The first move after release follows the normal 1-cycle latency.

## Test plan
- Reset, then X@4 (mark 10, loc 4) held 5 cycles → `a4` = 10 one cycle later, `countX` = 1, no further changes, `gameend` = 00.
- X@0, O@1, X@2, O@3, X@5, O@6 → `countX` = `countO` = 3, `fadeX` = 0, `fadeO` = 1. Then X@8 → `a0` = 00 and `a8` = 10 in the same cycle, `fadeX` = 2, `countX` = 3.
- X@0, O@3, X@1, O@4, X@2 → `gameend` = 10 two cycles after the X@2 input. A subsequent O@5 leaves `a5` = 00.
- Occupied target: X@4 then O@4 → `a4` stays 10, `countO` = 0.
- Out-of-range input: `location` = 9 with `mark` 10, and `mark` = 11 → no change.
- Elimination breaks a line: X holds 0,1 plus oldest at 7; X@2 while 7 is oldest → `a7` cleared, win at 0-1-2 detected.
- Same sequence with the oldest mark being 0 → 0 cleared, no win.
- Reset pulse mid-game → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/board_state.sv
// rtl/board_state.sv - nine-cell board with per-player three-mark elimination and win detection
module board_state (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] location,
  input  logic [1:0] mark,
  output logic [1:0] a0,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [1:0] gameend,
  output logic [3:0] fadeX,
  output logic [3:0] fadeO,
  output logic [1:0] countX,
  output logic [1:0] countO
);

  localparam logic [1:0] MARK_X   = 2'b10;
  localparam logic [1:0] MARK_O   = 2'b01;
  localparam logic [1:0] EMPTY    = 2'b00;
  localparam logic [3:0] LOC_NONE = 4'd9;

  // Board cells, index i holds cell i.
  logic [8:0][1:0] cell_q, cell_d;
  // Age queues, entry 0 is the oldest mark of that player.
  logic [2:0][3:0] qx_q, qx_d, qo_q, qo_d;
  logic [1:0]      cntx_q, cntx_d, cnto_q, cnto_d;
  logic [1:0]      gameend_q, gameend_d;
  logic [3:0]      prev_loc_q;
  logic [1:0]      prev_mark_q;

  logic is_player, in_range, is_new, target_empty, accept;

  // True when player p owns all three cells of any row, column or diagonal.
  function automatic logic has_line(input logic [8:0][1:0] b, input logic [1:0] p);
    has_line = (b[0] == p && b[1] == p && b[2] == p) ||
               (b[3] == p && b[4] == p && b[5] == p) ||
               (b[6] == p && b[7] == p && b[8] == p) ||
               (b[0] == p && b[3] == p && b[6] == p) ||
               (b[1] == p && b[4] == p && b[7] == p) ||
               (b[2] == p && b[5] == p && b[8] == p) ||
               (b[0] == p && b[4] == p && b[8] == p) ||
               (b[2] == p && b[4] == p && b[6] == p);
  endfunction

  // Move qualification: a fresh, in-range player move onto an empty cell while in play.
  always_comb begin
    is_player    = (mark == MARK_X) || (mark == MARK_O);
    in_range     = (location <= 4'd8);
    is_new       = ({location, mark} != {prev_loc_q, prev_mark_q});
    target_empty = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (location == 4'(i) && cell_q[i] == EMPTY) begin
        target_empty = 1'b1;
      end
    end
    accept = is_player && in_range && is_new && target_empty && (gameend_q == EMPTY);
  end

  // Next board and queue state: place the mark, evicting the mover's oldest when full.
  always_comb begin
    cell_d = cell_q;
    qx_d   = qx_q;
    qo_d   = qo_q;
    cntx_d = cntx_q;
    cnto_d = cnto_q;
    if (accept) begin
      if (mark == MARK_X) begin
        if (cntx_q == 2'd3) begin
          for (int i = 0; i < 9; i++) begin
            if (qx_q[0] == 4'(i)) begin
              cell_d[i] = EMPTY;
            end
          end
          qx_d = {location, qx_q[2], qx_q[1]};
        end else begin
          case (cntx_q)
            2'd0:    qx_d[0] = location;
            2'd1:    qx_d[1] = location;
            default: qx_d[2] = location;
          endcase
          cntx_d = cntx_q + 2'd1;
        end
      end else begin
        if (cnto_q == 2'd3) begin
          for (int i = 0; i < 9; i++) begin
            if (qo_q[0] == 4'(i)) begin
              cell_d[i] = EMPTY;
            end
          end
          qo_d = {location, qo_q[2], qo_q[1]};
        end else begin
          case (cnto_q)
            2'd0:    qo_d[0] = location;
            2'd1:    qo_d[1] = location;
            default: qo_d[2] = location;
          endcase
          cnto_d = cnto_q + 2'd1;
        end
      end
      // The evicted cell belongs to the mover and the target was empty, so they never collide.
      for (int i = 0; i < 9; i++) begin
        if (location == 4'(i)) begin
          cell_d[i] = mark;
        end
      end
    end
  end

  // Sticky winner, evaluated from the registered board; X wins a tie.
  always_comb begin
    gameend_d = gameend_q;
    if (gameend_q == EMPTY) begin
      if (has_line(cell_q, MARK_X)) begin
        gameend_d = MARK_X;
      end else if (has_line(cell_q, MARK_O)) begin
        gameend_d = MARK_O;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cell_q      <= '0;
      qx_q        <= {LOC_NONE, LOC_NONE, LOC_NONE};
      qo_q        <= {LOC_NONE, LOC_NONE, LOC_NONE};
      cntx_q      <= 2'd0;
      cnto_q      <= 2'd0;
      gameend_q   <= EMPTY;
      prev_loc_q  <= LOC_NONE;
      prev_mark_q <= EMPTY;
    end else begin
      cell_q      <= cell_d;
      qx_q        <= qx_d;
      qo_q        <= qo_d;
      cntx_q      <= cntx_d;
      cnto_q      <= cnto_d;
      gameend_q   <= gameend_d;
      prev_loc_q  <= location;
      prev_mark_q <= mark;
    end
  end

  assign a0      = cell_q[0];
  assign a1      = cell_q[1];
  assign a2      = cell_q[2];
  assign a3      = cell_q[3];
  assign a4      = cell_q[4];
  assign a5      = cell_q[5];
  assign a6      = cell_q[6];
  assign a7      = cell_q[7];
  assign a8      = cell_q[8];
  assign gameend = gameend_q;
  assign countX  = cntx_q;
  assign countO  = cnto_q;
  assign fadeX   = (cntx_q == 2'd3) ? qx_q[0] : LOC_NONE;
  assign fadeO   = (cnto_q == 2'd3) ? qo_q[0] : LOC_NONE;

endmodule

// File: tb/tb_board_state.sv
// tb/tb_board_state.sv - randomized and directed checks of board_state against a queue-based model
module tb_board_state;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] location = 4'd9;
  logic [1:0] mark = 2'b00;
  logic [1:0] a0, a1, a2, a3, a4, a5, a6, a7, a8, gameend, countX, countO;
  logic [3:0] fadeX, fadeO;

  board_state dut (
    .clk(clk), .rst(rst), .location(location), .mark(mark),
    .a0(a0), .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8),
    .gameend(gameend), .fadeX(fadeX), .fadeO(fadeO), .countX(countX), .countO(countO)
  );

  always #5 clk = ~clk;

  logic [17:0] board_act;
  assign board_act = {a8, a7, a6, a5, a4, a3, a2, a1, a0};

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int         m_board[9];
  int         qx[$];
  int         qo[$];
  logic [1:0] m_ge;
  int         m_ploc;
  int         m_pmark;

  int lines[8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6}, '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  function automatic logic owns_line(input int p);
    for (int l = 0; l < 8; l++)
      if (m_board[lines[l][0]] == p && m_board[lines[l][1]] == p && m_board[lines[l][2]] == p)
        return 1'b1;
    return 1'b0;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      foreach (m_board[i]) m_board[i] = 0;
      qx.delete();
      qo.delete();
      m_ge    = 2'b00;
      m_ploc  = 9;
      m_pmark = 0;
    end else begin
      logic [1:0] win;
      int loc, mk;
      win = owns_line(2) ? 2'b10 : (owns_line(1) ? 2'b01 : 2'b00);
      loc = int'(location);
      mk  = int'(mark);
      if ((mk == 2 || mk == 1) && loc <= 8 && !(loc == m_ploc && mk == m_pmark) &&
          m_ge == 2'b00 && m_board[loc] == 0) begin
        if (mk == 2) begin
          if (qx.size() == 3) m_board[qx.pop_front()] = 0;
          qx.push_back(loc);
        end else begin
          if (qo.size() == 3) m_board[qo.pop_front()] = 0;
          qo.push_back(loc);
        end
        m_board[loc] = mk;
      end
      m_ploc  = loc;
      m_pmark = mk;
      if (m_ge == 2'b00) m_ge = win;
    end
  end

  task automatic compare_all();
    logic [17:0] eb;
    for (int i = 0; i < 9; i++) eb[2*i +: 2] = 2'(m_board[i]);
    check("board", 32'(board_act), 32'(eb));
    check("gameend", 32'(gameend), 32'(m_ge));
    check("countX", 32'(countX), 32'(qx.size()));
    check("countO", 32'(countO), 32'(qo.size()));
    check("fadeX", 32'(fadeX), (qx.size() == 3) ? 32'(qx[0]) : 32'd9);
    check("fadeO", 32'(fadeO), (qo.size() == 3) ? 32'(qo[0]) : 32'd9);
  endtask

  // Per-cycle comparison away from the active edge.
  always @(negedge clk) if (rst) compare_all();

  // ---------------- stimulus helpers ----------------
  task automatic play(input int l, input logic [1:0] m);
    location = 4'(l);
    mark     = m;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    location = 4'd9;
    mark = 2'b00;
    @(negedge clk);
    rst = 1'b1;
  endtask

  localparam logic [1:0] X = 2'b10;
  localparam logic [1:0] O = 2'b01;

  initial begin
    @(negedge clk);
    // Reset values.
    check("rst_board", 32'(board_act), 32'd0);
    check("rst_gameend", 32'(gameend), 32'd0);
    check("rst_fadeX", 32'(fadeX), 32'd9);
    check("rst_fadeO", 32'(fadeO), 32'd9);
    check("rst_counts", {28'd0, countX, countO}, 32'd0);
    rst = 1'b1;

    // Held pair yields one event.
    play(4, X);
    repeat (4) @(negedge clk);
    check("held_a4", 32'(a4), 32'(X));
    check("held_countX", 32'(countX), 32'd1);
    check("held_gameend", 32'(gameend), 32'd0);

    // Full queues and elimination.
    do_reset();
    play(0, X); play(1, O); play(2, X); play(3, O); play(5, X); play(6, O);
    check("full_countX", 32'(countX), 32'd3);
    check("full_countO", 32'(countO), 32'd3);
    check("full_fadeX", 32'(fadeX), 32'd0);
    check("full_fadeO", 32'(fadeO), 32'd1);
    play(8, X);
    check("elim_a0", 32'(a0), 32'd0);
    check("elim_a8", 32'(a8), 32'(X));
    check("elim_fadeX", 32'(fadeX), 32'd2);
    check("elim_countX", 32'(countX), 32'd3);

    // Win latency and freeze.
    do_reset();
    play(0, X); play(3, O); play(1, X); play(4, O); play(2, X);
    check("win_t1_gameend", 32'(gameend), 32'd0);
    @(negedge clk);
    check("win_t2_gameend", 32'(gameend), 32'(X));
    play(5, O);
    @(negedge clk);
    check("frozen_a5", 32'(a5), 32'd0);

    // Occupied target, drop-and-return, out-of-range inputs.
    do_reset();
    play(4, X); play(4, O);
    check("occ_a4", 32'(a4), 32'(X));
    check("occ_countO", 32'(countO), 32'd0);
    play(4, 2'b00); play(4, X);
    check("repeat_countX", 32'(countX), 32'd1);
    play(9, X); play(0, 2'b11); play(15, O);
    check("oor_board", 32'(board_act), 32'(X) << 8);

    // Elimination clears 7, leaving 0-1-2 winning.
    do_reset();
    play(7, X); play(3, O); play(0, X); play(4, O); play(1, X); play(8, O); play(2, X);
    check("brk_a7", 32'(a7), 32'd0);
    check("brk_a2", 32'(a2), 32'(X));
    @(negedge clk);
    check("brk_gameend", 32'(gameend), 32'(X));

    // Elimination clears 0, no win.
    do_reset();
    play(0, X); play(3, O); play(1, X); play(4, O); play(7, X); play(8, O); play(2, X);
    check("nowin_a0", 32'(a0), 32'd0);
    repeat (2) @(negedge clk);
    check("nowin_gameend", 32'(gameend), 32'd0);

    // Asynchronous reset mid-game.
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("async_board", 32'(board_act), 32'd0);
    check("async_counts", {28'd0, countX, countO}, 32'd0);
    check("async_fades", {24'd0, fadeX, fadeO}, 32'h99);
    check("async_gameend", 32'(gameend), 32'd0);
    location = 4'd9;
    mark = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    play(6, O);
    check("post_rst_a6", 32'(a6), 32'(O));

    // Randomized play with resets after games end.
    for (int n = 0; n < 3000; n++) begin
      int l;
      logic [1:0] m;
      if (m_ge != 2'b00 && $urandom_range(0, 3) == 0) begin
        do_reset();
      end else begin
        l = ($urandom_range(0, 15) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
        m = 2'($urandom_range(0, 3));
        repeat ($urandom_range(1, 3)) play(l, m);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
